// File: rtl/sc_scbc_msas.sv
`default_nettype none
// ============================================================================
// Module   : sc_scbc_msas
// Purpose  : Multi-root Slave Access Selector. This is the register-bus front
//            end of the Space Communication Bus Controller.
//            - Bus accesses are split into synchronous (same-cycle) and
//              asynchronous (handshaked) register accesses.
//            - Read data is steered from NUM_ROOT register roots.
//            - Every asynchronous access has a completion timeout. When the
//              timeout expires, the block reports a bus error.
// Ports    : SYSCLK/SYSRST  - clock, synchronous active-high reset
//            RB_W*/RB_R*    - system register bus write/read channels
//            DEC_*          - classification from the external address decoder
//            SYNC_*/ASYNC_* - strobes and completions on the slave side
//            WADR/WDAT/WENB - write address/data/enables to the slaves
//            RADR           - read address to the slaves
//            ROOT_RDAT      - packed root read data (root i at [32*i +: 32])
//            ERR_STS        - sticky {read timeout, write timeout}
//            ERR_CLR        - clears ERR_STS
// Revision : 1.0 - initial release
// ============================================================================
module sc_scbc_msas #(
    parameter int  ADDR_WIDTH    = 32,
    parameter int  NUM_ROOT      = 4,
    parameter int  ASYNC_TIMEOUT = 255,
    localparam int RSW           = $clog2(NUM_ROOT)
) (
    input  logic                   SYSCLK,
    input  logic                   SYSRST,
    // register bus, write channel
    input  logic [ADDR_WIDTH-1:0]  RB_WADR,
    input  logic [31:0]            RB_WDAT,
    input  logic [3:0]             RB_WENB,
    output logic                   RB_WWAT,
    output logic                   RB_WERR,
    // register bus, read channel
    input  logic [ADDR_WIDTH-1:0]  RB_RADR,
    input  logic                   RB_RENB,
    output logic [31:0]            RB_RDAT,
    output logic                   RB_RWAT,
    output logic                   RB_RERR,
    // decoder
    input  logic                   DEC_W_ASYNC,
    input  logic                   DEC_R_ASYNC,
    input  logic [RSW-1:0]         DEC_R_ROOT,
    // slave side, write
    output logic                   SYNC_WENB,
    output logic                   ASYNC_WENB,
    input  logic                   ASYNC_WCOMP,
    output logic [ADDR_WIDTH-1:0]  WADR,
    output logic [31:0]            WDAT,
    output logic [3:0]             WENB,
    // slave side, read
    output logic                   SYNC_RENB,
    output logic                   ASYNC_RENB,
    input  logic                   ASYNC_RCOMP,
    output logic [ADDR_WIDTH-1:0]  RADR,
    input  logic [32*NUM_ROOT-1:0] ROOT_RDAT,
    // error status
    output logic [1:0]             ERR_STS,
    input  logic                   ERR_CLR
);

    // The counter width must be at least 1 bit, even when the timeout is disabled.
    localparam int              TW               = (ASYNC_TIMEOUT > 0) ? $clog2(ASYNC_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   c_timeout        = TW'(ASYNC_TIMEOUT);
    localparam logic            c_timeout_en     = (ASYNC_TIMEOUT > 0);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_BUSY = 1'b1} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_SYNC = 2'd1, R_ASYNC = 2'd2} rstate_t;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t                r_wstate;
    wstate_t                w_wstate_nxt;
    logic [ADDR_WIDTH-1:0]  r_wadr;
    logic [31:0]            r_wdat;
    logic [3:0]             r_wenb;
    logic [TW-1:0]          r_wcnt;
    logic                   w_wreq;
    logic                   w_wlatch;
    logic                   w_wtmo;

    assign w_wreq = |RB_WENB;
    // A completion in the same cycle as the timeout takes priority over the timeout.
    assign w_wtmo = c_timeout_en && (r_wstate == W_BUSY) && (r_wcnt == c_timeout) && !ASYNC_WCOMP;

    always_comb begin : p_wfsm_comb
        w_wstate_nxt = r_wstate;
        w_wlatch     = 1'b0;
        SYNC_WENB    = 1'b0;
        ASYNC_WENB   = 1'b0;
        RB_WWAT      = 1'b0;
        RB_WERR      = 1'b0;
        WADR         = '0;
        WDAT         = '0;
        WENB         = '0;
        case (r_wstate)
            W_IDLE: begin
                if (w_wreq) begin
                    WADR = RB_WADR;
                    WDAT = RB_WDAT;
                    WENB = RB_WENB;
                    if (DEC_W_ASYNC) begin
                        // The async write is posted. The slave sees the
                        // strobe now and the latched copy while busy.
                        ASYNC_WENB   = 1'b1;
                        w_wlatch     = 1'b1;
                        w_wstate_nxt = W_BUSY;
                    end else begin
                        SYNC_WENB = 1'b1;
                    end
                end
            end
            W_BUSY: begin
                WADR = r_wadr;
                WDAT = r_wdat;
                WENB = r_wenb;
                // On a timeout, a waiting write ends with an error and is dropped.
                RB_WWAT = w_wreq & ~w_wtmo;
                RB_WERR = w_wreq &  w_wtmo;
                if (ASYNC_WCOMP || w_wtmo) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin : p_wfsm_seq
        if (SYSRST) begin
            r_wstate <= W_IDLE;
            r_wadr   <= '0;
            r_wdat   <= '0;
            r_wenb   <= '0;
            r_wcnt   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_wlatch) begin
                r_wadr <= RB_WADR;
                r_wdat <= RB_WDAT;
                r_wenb <= RB_WENB;
                r_wcnt <= '0;
            end else if (r_wstate == W_BUSY) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t                r_rstate;
    rstate_t                w_rstate_nxt;
    logic [RSW-1:0]         r_rsel;
    logic [ADDR_WIDTH-1:0]  r_radr;
    logic [TW-1:0]          r_rcnt;
    logic [31:0]            r_rdat;      // captured async data, nonzero only in its data cycle
    logic                   r_rerr_cap;  // the captured async access used an invalid root
    logic                   w_raccept;
    logic                   w_rcapt;
    logic                   w_rtmo;
    logic [31:0]            w_root_dat;
    logic                   w_root_ok;

    assign w_rtmo = c_timeout_en && (r_rstate == R_ASYNC) && (r_rcnt == c_timeout) && !ASYNC_RCOMP;

    // Root select mux. An index with no matching root gives zero data and is
    // flagged as invalid.
    always_comb begin : p_root_mux
        w_root_dat = '0;
        w_root_ok  = 1'b0;
        for (int i = 0; i < NUM_ROOT; i++) begin
            if (r_rsel == RSW'(i)) begin
                w_root_dat = ROOT_RDAT[32*i +: 32];
                w_root_ok  = 1'b1;
            end
        end
    end

    always_comb begin : p_rfsm_comb
        w_rstate_nxt = r_rstate;
        w_raccept    = 1'b0;
        w_rcapt      = 1'b0;
        SYNC_RENB    = 1'b0;
        ASYNC_RENB   = 1'b0;
        RADR         = '0;
        RB_RDAT      = '0;
        RB_RWAT      = 1'b0;
        RB_RERR      = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                RB_RDAT = r_rdat;
                RB_RERR = r_rerr_cap;
                if (RB_RENB) begin
                    RADR      = RB_RADR;
                    w_raccept = 1'b1;
                    if (DEC_R_ASYNC) begin
                        ASYNC_RENB   = 1'b1;
                        w_rstate_nxt = R_ASYNC;
                    end else begin
                        SYNC_RENB    = 1'b1;
                        w_rstate_nxt = R_SYNC;
                    end
                end
            end
            R_SYNC: begin
                // This is the data cycle. New requests wait until the next cycle.
                RADR         = r_radr;
                RB_RDAT      = w_root_dat;
                RB_RERR      = ~w_root_ok;
                w_rstate_nxt = R_IDLE;
            end
            R_ASYNC: begin
                // The timeout cycle is itself the (error) completion cycle.
                RADR    = r_radr;
                RB_RWAT = ~w_rtmo;
                RB_RERR = w_rtmo;
                if (ASYNC_RCOMP) begin
                    w_rcapt      = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end else if (w_rtmo) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge SYSCLK) begin : p_rfsm_seq
        if (SYSRST) begin
            r_rstate   <= R_IDLE;
            r_rsel     <= '0;
            r_radr     <= '0;
            r_rcnt     <= '0;
            r_rdat     <= '0;
            r_rerr_cap <= 1'b0;
        end else begin
            r_rstate   <= w_rstate_nxt;
            r_rdat     <= w_rcapt ? w_root_dat : 32'h0;
            r_rerr_cap <= w_rcapt & ~w_root_ok;
            if (w_raccept) begin
                r_rsel <= DEC_R_ROOT;
                r_radr <= RB_RADR;
                r_rcnt <= '0;
            end else if (r_rstate == R_ASYNC) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error status. A new event overrides a simultaneous clear.
    // ------------------------------------------------------------------
    logic [1:0] r_err_sts;

    always_ff @(posedge SYSCLK) begin : p_err_sts
        if (SYSRST) begin
            r_err_sts <= 2'b00;
        end else begin
            r_err_sts <= {w_rtmo, w_wtmo} | (r_err_sts & ~{2{ERR_CLR}});
        end
    end

    assign ERR_STS = r_err_sts;

endmodule
`default_nettype wire

// File: tb/tb_sc_scbc_msas.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_scbc_msas
// Purpose  : Self-checking bench for sc_scbc_msas (NUM_ROOT=3, timeout 8).
//            - Directed scenarios are checked against hand-computed literals.
//            - Randomized traffic is checked on every cycle against a
//              transaction-level model of the selector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_scbc_msas;

    localparam int AW  = 32;
    localparam int NR  = 3;
    localparam int TMO = 8;
    localparam int RSW = 2;

    logic              SYSCLK = 1'b0;
    logic              SYSRST;
    logic [AW-1:0]     RB_WADR, RB_RADR, WADR, RADR;
    logic [31:0]       RB_WDAT, RB_RDAT, WDAT;
    logic [3:0]        RB_WENB, WENB;
    logic              RB_WWAT, RB_WERR, RB_RENB, RB_RWAT, RB_RERR;
    logic              DEC_W_ASYNC, DEC_R_ASYNC;
    logic [RSW-1:0]    DEC_R_ROOT;
    logic              SYNC_WENB, ASYNC_WENB, ASYNC_WCOMP;
    logic              SYNC_RENB, ASYNC_RENB, ASYNC_RCOMP;
    logic [32*NR-1:0]  ROOT_RDAT;
    logic [1:0]        ERR_STS;
    logic              ERR_CLR;

    sc_scbc_msas #(.ADDR_WIDTH(AW), .NUM_ROOT(NR), .ASYNC_TIMEOUT(TMO)) dut (
        .SYSCLK(SYSCLK), .SYSRST(SYSRST),
        .RB_WADR(RB_WADR), .RB_WDAT(RB_WDAT), .RB_WENB(RB_WENB),
        .RB_WWAT(RB_WWAT), .RB_WERR(RB_WERR),
        .RB_RADR(RB_RADR), .RB_RENB(RB_RENB), .RB_RDAT(RB_RDAT),
        .RB_RWAT(RB_RWAT), .RB_RERR(RB_RERR),
        .DEC_W_ASYNC(DEC_W_ASYNC), .DEC_R_ASYNC(DEC_R_ASYNC), .DEC_R_ROOT(DEC_R_ROOT),
        .SYNC_WENB(SYNC_WENB), .ASYNC_WENB(ASYNC_WENB), .ASYNC_WCOMP(ASYNC_WCOMP),
        .WADR(WADR), .WDAT(WDAT), .WENB(WENB),
        .SYNC_RENB(SYNC_RENB), .ASYNC_RENB(ASYNC_RENB), .ASYNC_RCOMP(ASYNC_RCOMP),
        .RADR(RADR), .ROOT_RDAT(ROOT_RDAT),
        .ERR_STS(ERR_STS), .ERR_CLR(ERR_CLR)
    );

    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [31:0] root_word(input int sel, input logic [32*NR-1:0] bus);
        if (sel < NR) return bus[32*sel +: 32];
        return 32'h0;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    // Pending posted async write: latched copy and age counted in busy cycles.
    logic          m_wpend = 1'b0;
    logic [AW-1:0] m_wadr  = '0;
    logic [31:0]   m_wdat  = '0;
    logic [3:0]    m_wbe   = '0;
    int            m_wage  = 0;
    // Outstanding read: a sync data cycle is due, or an async read is pending.
    logic          m_rsync = 1'b0;
    logic          m_rapend = 1'b0;
    int            m_rsel  = 0;
    logic [AW-1:0] m_radr  = '0;
    int            m_rage  = 0;
    // Async read result shown in the cycle after completion.
    logic          m_adue  = 1'b0;
    logic [31:0]   m_adat  = '0;
    logic          m_aerr  = 1'b0;
    logic [1:0]    m_err   = 2'b00;

    always @(negedge SYSCLK) begin : p_compare
        logic        wreq, wt, rt;
        logic        x_swenb, x_awenb, x_wwat, x_werr, x_srenb, x_arenb, x_rwat, x_rerr;
        logic [31:0] x_wadr, x_wdat, x_radr, x_rdat;
        logic [3:0]  x_wenb;

        wreq = |RB_WENB;
        wt   = m_wpend  && (m_wage == TMO) && !ASYNC_WCOMP;
        rt   = m_rapend && (m_rage == TMO) && !ASYNC_RCOMP;

        x_swenb = 0; x_awenb = 0; x_wwat = 0; x_werr = 0;
        x_srenb = 0; x_arenb = 0; x_rwat = 0; x_rerr = 0;
        x_wadr = '0; x_wdat = '0; x_wenb = '0; x_radr = '0; x_rdat = '0;

        if (!m_wpend) begin
            if (wreq) begin
                x_wadr  = RB_WADR; x_wdat = RB_WDAT; x_wenb = RB_WENB;
                x_swenb = !DEC_W_ASYNC;
                x_awenb = DEC_W_ASYNC;
            end
        end else begin
            x_wadr = m_wadr; x_wdat = m_wdat; x_wenb = m_wbe;
            x_wwat = wreq && !wt;
            x_werr = wreq && wt;
        end

        if (m_rsync) begin
            x_radr = m_radr;
            x_rdat = root_word(m_rsel, ROOT_RDAT);
            x_rerr = (m_rsel >= NR);
        end else if (m_rapend) begin
            x_radr = m_radr;
            x_rwat = !rt;
            x_rerr = rt;
        end else begin
            x_rdat = m_adue ? m_adat : 32'h0;
            x_rerr = m_adue && m_aerr;
            if (RB_RENB) begin
                x_radr  = RB_RADR;
                x_srenb = !DEC_R_ASYNC;
                x_arenb = DEC_R_ASYNC;
            end
        end

        chk1("sync_wenb", SYNC_WENB, x_swenb);
        chk1("async_wenb", ASYNC_WENB, x_awenb);
        chk1("rb_wwat", RB_WWAT, x_wwat);
        chk1("rb_werr", RB_WERR, x_werr);
        chk("wadr", WADR, x_wadr);
        chk("wdat", WDAT, x_wdat);
        chk("wenb", {28'b0, WENB}, {28'b0, x_wenb});
        chk1("sync_renb", SYNC_RENB, x_srenb);
        chk1("async_renb", ASYNC_RENB, x_arenb);
        chk1("rb_rwat", RB_RWAT, x_rwat);
        chk1("rb_rerr", RB_RERR, x_rerr);
        chk("radr", RADR, x_radr);
        chk("rb_rdat", RB_RDAT, x_rdat);
        chk("err_sts", {30'b0, ERR_STS}, {30'b0, m_err});

        // Advance the model using the inputs that the next rising edge samples.
        if (SYSRST) begin
            m_wpend = 0; m_wadr = '0; m_wdat = '0; m_wbe = '0; m_wage = 0;
            m_rsync = 0; m_rapend = 0; m_rsel = 0; m_radr = '0; m_rage = 0;
            m_adue = 0; m_adat = '0; m_aerr = 0; m_err = 2'b00;
        end else begin
            if (!m_wpend) begin
                if (wreq && DEC_W_ASYNC) begin
                    m_wpend = 1; m_wadr = RB_WADR; m_wdat = RB_WDAT; m_wbe = RB_WENB; m_wage = 0;
                end
            end else if (ASYNC_WCOMP || wt) begin
                m_wpend = 0;
            end else begin
                m_wage++;
            end

            m_adue = 0;
            if (m_rsync) begin
                m_rsync = 0;
            end else if (m_rapend) begin
                if (ASYNC_RCOMP) begin
                    m_rapend = 0;
                    m_adue   = 1;
                    m_adat   = root_word(m_rsel, ROOT_RDAT);
                    m_aerr   = (m_rsel >= NR);
                end else if (rt) begin
                    m_rapend = 0;
                end else begin
                    m_rage++;
                end
            end else if (RB_RENB) begin
                m_rsel = int'(DEC_R_ROOT);
                m_radr = RB_RADR;
                if (DEC_R_ASYNC) begin
                    m_rapend = 1; m_rage = 0;
                end else begin
                    m_rsync = 1;
                end
            end

            m_err = (m_err & ~{ERR_CLR, ERR_CLR}) | {rt, wt};
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 time unit after the rising edge. Literal
    // checks are made 3 units later, before the falling edge.
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin : p_stim
        SYSRST = 1; RB_WADR = '0; RB_WDAT = '0; RB_WENB = '0; RB_RADR = '0; RB_RENB = 0;
        DEC_W_ASYNC = 0; DEC_R_ASYNC = 0; DEC_R_ROOT = '0; ASYNC_WCOMP = 0; ASYNC_RCOMP = 0;
        ROOT_RDAT = '0; ERR_CLR = 0;

        // Reset state
        repeat (2) next_cycle();
        settle();
        chk("rst_rdat", RB_RDAT, 32'h0);
        chk1("rst_wwat", RB_WWAT, 1'b0);
        chk1("rst_rwat", RB_RWAT, 1'b0);
        chk("rst_err_sts", {30'b0, ERR_STS}, 32'h0);
        next_cycle(); SYSRST = 0;

        // Sync write
        next_cycle();
        RB_WENB = 4'hF; RB_WADR = 32'h0000_0104; RB_WDAT = 32'hA5A5_0001; DEC_W_ASYNC = 0;
        settle();
        chk1("t1_sync_wenb", SYNC_WENB, 1'b1);
        chk("t1_wdat", WDAT, 32'hA5A5_0001);
        chk1("t1_wwat", RB_WWAT, 1'b0);

        // Async write at cycle 0, second write at cycle 2, completion at cycle 5
        next_cycle();
        RB_WADR = 32'h0000_0100; RB_WDAT = 32'h0000_0011; DEC_W_ASYNC = 1;
        settle();
        chk1("t2_async_wenb", ASYNC_WENB, 1'b1);
        chk1("t2_c0_wwat", RB_WWAT, 1'b0);
        next_cycle(); RB_WENB = 4'h0; DEC_W_ASYNC = 0;
        settle();
        chk("t2_c1_wadr_latched", WADR, 32'h0000_0100);
        next_cycle(); RB_WENB = 4'h3; RB_WADR = 32'h0000_0200; RB_WDAT = 32'h0000_0022;
        settle();
        chk1("t2_c2_wwat", RB_WWAT, 1'b1);
        chk1("t2_c2_sync_wenb", SYNC_WENB, 1'b0);
        for (int c = 3; c <= 5; c++) begin
            next_cycle(); ASYNC_WCOMP = (c == 5);
            settle();
            chk1("t2_wwat_held", RB_WWAT, 1'b1);
            chk("t2_wadr_held", WADR, 32'h0000_0100);
        end
        next_cycle(); ASYNC_WCOMP = 0;
        settle();
        chk1("t2_c6_sync_wenb", SYNC_WENB, 1'b1);
        chk("t2_c6_wdat", WDAT, 32'h0000_0022);
        chk1("t2_c6_wwat", RB_WWAT, 1'b0);
        next_cycle(); RB_WENB = 4'h0;

        // Async read from root 2, completion at cycle 3
        next_cycle();
        ROOT_RDAT = {32'h1234_5678, 32'h1111_1111, 32'h2222_2222};
        RB_RENB = 1; RB_RADR = 32'h0000_0300; DEC_R_ASYNC = 1; DEC_R_ROOT = 2'd2;
        settle();
        chk1("t3_async_renb", ASYNC_RENB, 1'b1);
        next_cycle(); RB_RENB = 0; DEC_R_ASYNC = 0; DEC_R_ROOT = 2'd0;
        settle();
        chk1("t3_c1_rwat", RB_RWAT, 1'b1);
        chk("t3_c1_radr", RADR, 32'h0000_0300);
        next_cycle(); settle();
        chk1("t3_c2_rwat", RB_RWAT, 1'b1);
        next_cycle(); ASYNC_RCOMP = 1;
        settle();
        chk1("t3_c3_rwat", RB_RWAT, 1'b1);
        next_cycle(); ASYNC_RCOMP = 0; ROOT_RDAT = {32'hBAD0_BAD0, 32'h1111_1111, 32'h2222_2222};
        settle();
        chk1("t3_c4_rwat", RB_RWAT, 1'b0);
        chk("t3_c4_rdat", RB_RDAT, 32'h1234_5678);
        chk1("t3_c4_rerr", RB_RERR, 1'b0);

        // Async read timeout (no completion): the error appears at cycle 9
        next_cycle(); RB_RENB = 1; DEC_R_ASYNC = 1; DEC_R_ROOT = 2'd1;
        next_cycle(); RB_RENB = 0; DEC_R_ASYNC = 0; DEC_R_ROOT = 2'd0;
        repeat (7) next_cycle();
        settle();
        chk1("t4_c8_rwat", RB_RWAT, 1'b1);
        chk1("t4_c8_rerr", RB_RERR, 1'b0);
        next_cycle(); settle();
        chk1("t4_c9_rerr", RB_RERR, 1'b1);
        chk("t4_c9_rdat", RB_RDAT, 32'h0);
        next_cycle(); ERR_CLR = 1;
        settle();
        chk("t4_err_sts_set", {30'b0, ERR_STS}, 32'h2);
        next_cycle(); ERR_CLR = 0;
        settle();
        chk("t4_err_sts_clr", {30'b0, ERR_STS}, 32'h0);

        // Completion in the exact timeout cycle wins
        next_cycle(); RB_RENB = 1; DEC_R_ASYNC = 1; DEC_R_ROOT = 2'd1;
        ROOT_RDAT = {32'h0, 32'hDEAD_BEEF, 32'h0};
        next_cycle(); RB_RENB = 0; DEC_R_ASYNC = 0; DEC_R_ROOT = 2'd0;
        repeat (7) next_cycle();
        next_cycle(); ASYNC_RCOMP = 1;
        settle();
        chk1("t5_c9_rerr", RB_RERR, 1'b0);
        next_cycle(); ASYNC_RCOMP = 0;
        settle();
        chk("t5_rdat", RB_RDAT, 32'hDEAD_BEEF);
        chk1("t5_rerr", RB_RERR, 1'b0);
        next_cycle(); settle();
        chk("t5_err_sts", {30'b0, ERR_STS}, 32'h0);

        // Root index out of range (NUM_ROOT=3)
        next_cycle(); RB_RENB = 1; DEC_R_ASYNC = 0; DEC_R_ROOT = 2'd3;
        ROOT_RDAT = {32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        settle();
        chk1("t6_sync_renb", SYNC_RENB, 1'b1);
        next_cycle(); RB_RENB = 0; DEC_R_ROOT = 2'd0;
        settle();
        chk1("t6_rerr", RB_RERR, 1'b1);
        chk("t6_rdat", RB_RDAT, 32'h0);

        // Reset during a pending async write; a late completion is ignored
        next_cycle(); RB_WENB = 4'hF; RB_WADR = 32'h0000_0400; RB_WDAT = 32'h0000_0044; DEC_W_ASYNC = 1;
        next_cycle(); RB_WENB = 4'h0; DEC_W_ASYNC = 0; SYSRST = 1;
        settle();
        chk("t7_busy_wadr", WADR, 32'h0000_0400);
        next_cycle(); SYSRST = 0; ASYNC_WCOMP = 1;
        settle();
        chk("t7_rst_wadr", WADR, 32'h0);
        chk("t7_rst_wdat", WDAT, 32'h0);
        chk1("t7_rst_wwat", RB_WWAT, 1'b0);
        chk("t7_rst_err_sts", {30'b0, ERR_STS}, 32'h0);
        next_cycle(); ASYNC_WCOMP = 0; RB_WENB = 4'hF; RB_WDAT = 32'h0000_0055;
        settle();
        chk1("t7_idle_sync_wenb", SYNC_WENB, 1'b1);
        chk("t7_idle_wdat", WDAT, 32'h0000_0055);
        next_cycle(); RB_WENB = 4'h0;

        // Randomized traffic on both channels
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            SYSRST      = ($urandom_range(0, 299) == 0);
            RB_WENB     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            RB_WADR     = $urandom;
            RB_WDAT     = $urandom;
            DEC_W_ASYNC = 1'($urandom_range(0, 1));
            RB_RENB     = ($urandom_range(0, 2) == 0);
            RB_RADR     = $urandom;
            DEC_R_ASYNC = 1'($urandom_range(0, 1));
            DEC_R_ROOT  = 2'($urandom_range(0, 3));
            ASYNC_WCOMP = ($urandom_range(0, 9) == 0);
            ASYNC_RCOMP = ($urandom_range(0, 9) == 0);
            ERR_CLR     = ($urandom_range(0, 29) == 0);
            ROOT_RDAT   = {$urandom, $urandom, $urandom};
        end

        next_cycle();
        SYSRST = 0; RB_WENB = '0; RB_RENB = 0; ASYNC_WCOMP = 0; ASYNC_RCOMP = 0; ERR_CLR = 0;
        repeat (2) next_cycle();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
